// File: rtl/logic_function_unit.sv
// logic_function_unit: evaluates eight Boolean functions of a WIDTH-bit operand,
// with a button-stepped mode selector and a built-in truth-table sweep that
// cross-checks the reduction datapath against an independent reference.
module logic_function_unit #(
  parameter int WIDTH           = 3,
  parameter int THRESH          = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_bits,
  input  logic                       en,
  input  logic                       mode_step,
  input  logic                       sweep_start,
  input  logic                       check_invert,
  output logic [7:0]                 out_vec,
  output logic                       out_bit,
  output logic [2:0]                 mode,
  output logic [$clog2(WIDTH+1)-1:0] ones_count,
  output logic                       sweep_busy,
  output logic                       sweep_done,
  output logic                       sweep_fail
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef logic [WIDTH-1:0] op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_e;

  // Control bit positions inside the synchronizer vector.
  localparam int C_EN   = 0;
  localparam int C_STEP = 1;
  localparam int C_SWP  = 2;
  localparam int C_INV  = 3;

  // Ones count of a minterm index; used only with loop constants, so it folds away.
  function automatic int popcount_int(input int unsigned v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  op_t                  bits_s1_q, bits_s2_q;
  logic [3:0]           ctl_s1_q, ctl_s2_q;
  logic [1:0]           db_raw;
  logic [1:0]           db_level_q, db_level_d;
  logic [1:0]           db_pulse_q, db_pulse_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]           mode_q, mode_d;
  state_e               state_q, state_d;
  op_t                  cnt_q, cnt_d;
  logic                 fail_q, fail_d;
  op_t                  operand;
  logic [CNT_W-1:0]     ones;
  logic [7:0]           func_vec;
  logic [7:0]           ref_vec;
  logic                 ref_maj, ref_one, ref_thr;
  logic                 mismatch;
  logic                 gate;
  logic [7:0]           out_vec_q, out_vec_d;
  logic                 out_bit_q, out_bit_d;
  logic [CNT_W-1:0]     ones_q;
  logic                 busy;

  assign busy   = (state_q == SWEEP);
  assign db_raw = {ctl_s2_q[C_SWP], ctl_s2_q[C_STEP]};

  // Two-flop synchronizers for every asynchronous input.
  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bits_s1_q <= '0;
      bits_s2_q <= '0;
      ctl_s1_q  <= '0;
      ctl_s2_q  <= '0;
    end else begin
      bits_s1_q <= in_bits;
      bits_s2_q <= bits_s1_q;
      ctl_s1_q  <= {check_invert, sweep_start, mode_step, en};
      ctl_s2_q  <= ctl_s1_q;
    end
  end

  // Debounce both buttons: flip the level after DEBOUNCE_CYCLES consecutive differing samples.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    db_pulse_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (db_raw[b] != db_level_q[b]) begin
        if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level_d[b] = db_raw[b];
          db_cnt_d[b]   = '0;
          db_pulse_d[b] = db_raw[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end else begin
        db_cnt_d[b] = '0;
      end
    end
  end

  // Debounce state registers; the pulse is high for the one cycle after a rising flip.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_level_q <= '0;
      db_pulse_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      db_level_q <= db_level_d;
      db_pulse_q <= db_pulse_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Datapath: the sweep counter replaces the live operand while sweeping.
  always_comb begin
    operand = busy ? cnt_q : bits_s2_q;
    ones    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CNT_W'(operand[i]);
    end
    func_vec[0] = &operand;
    func_vec[1] = |operand;
    func_vec[2] = ^operand;
    func_vec[3] = |(~operand);
    func_vec[4] = &(~operand);
    func_vec[5] = (32'(ones) << 1) > 32'(WIDTH);
    func_vec[6] = (ones == CNT_W'(1));
    func_vec[7] = (ones >= CNT_W'(THRESH));
  end

  // Reference: count-based for the reductions, sum of minterms for modes 5-7.
  always_comb begin
    ref_maj = 1'b0;
    ref_one = 1'b0;
    ref_thr = 1'b0;
    for (int m = 0; m < (1 << WIDTH); m++) begin
      if (operand == op_t'(m)) begin
        ref_maj = ref_maj | (2 * popcount_int(m) > WIDTH);
        ref_one = ref_one | (popcount_int(m) == 1);
        ref_thr = ref_thr | (popcount_int(m) >= THRESH);
      end
    end
    ref_vec[0] = (ones == CNT_W'(WIDTH));
    ref_vec[1] = (ones != '0);
    ref_vec[2] = ones[0];
    ref_vec[3] = !(ones == CNT_W'(WIDTH));
    ref_vec[4] = !(ones != '0);
    ref_vec[5] = ref_maj;
    ref_vec[6] = ref_one;
    ref_vec[7] = ref_thr;
    ref_vec    = ref_vec ^ {8{ctl_s2_q[C_INV]}};
    mismatch   = |(func_vec ^ ref_vec);
  end

  // Sweep FSM next state, counter and sticky fail flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (db_pulse_q[1]) begin
          state_d = SWEEP;
          cnt_d   = '0;
          fail_d  = 1'b0;
        end
      end
      SWEEP: begin
        if (mismatch) fail_d = 1'b1;
        if (cnt_q == '1) state_d = DONE;
        else             cnt_d   = cnt_q + op_t'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode stepping (locked during a sweep) and gated output register inputs.
  always_comb begin
    mode_d    = (db_pulse_q[0] && !busy) ? mode_q + 3'd1 : mode_q;
    gate      = ctl_s2_q[C_EN] | busy;
    out_vec_d = gate ? func_vec : '0;
    out_bit_d = gate & func_vec[mode_q];
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fail_q    <= 1'b0;
      mode_q    <= '0;
      out_vec_q <= '0;
      out_bit_q <= 1'b0;
      ones_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fail_q    <= fail_d;
      mode_q    <= mode_d;
      out_vec_q <= out_vec_d;
      out_bit_q <= out_bit_d;
      ones_q    <= ones;
    end
  end

  assign out_vec    = out_vec_q;
  assign out_bit    = out_bit_q;
  assign mode       = mode_q;
  assign ones_count = ones_q;
  assign sweep_busy = busy;
  assign sweep_done = (state_q == DONE);
  assign sweep_fail = fail_q;

endmodule

// File: tb/tb_logic_function_unit.sv
// Self-checking bench for logic_function_unit (WIDTH=3, THRESH=2, DEBOUNCE_CYCLES=4).
module tb_logic_function_unit;

  localparam int W  = 3;
  localparam int TH = 2;
  localparam int DB = 4;
  localparam int CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  in_bits = '0;
  logic          en = 1'b0, mode_step = 1'b0, sweep_start = 1'b0, check_invert = 1'b0;
  logic [7:0]    out_vec;
  logic          out_bit;
  logic [2:0]    mode;
  logic [CW-1:0] ones_count;
  logic          sweep_busy, sweep_done, sweep_fail;

  int n_cmp = 0;
  int n_err = 0;
  int model_mode = 0;

  logic_function_unit #(.WIDTH(W), .THRESH(TH), .DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .in_bits(in_bits), .en(en),
    .mode_step(mode_step), .sweep_start(sweep_start), .check_invert(check_invert),
    .out_vec(out_vec), .out_bit(out_bit), .mode(mode), .ones_count(ones_count),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_fail(sweep_fail)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Behavioural model: every function computed directly from the ones count.
  function automatic logic [7:0] model_vec(input logic [W-1:0] op);
    int c;
    logic [7:0] v;
    c    = $countones(op);
    v[0] = (c == W);
    v[1] = (c != 0);
    v[2] = (c % 2 == 1);
    v[3] = (c != W);
    v[4] = (c == 0);
    v[5] = (2 * c > W);
    v[6] = (c == 1);
    v[7] = (c >= TH);
    return v;
  endfunction

  function automatic logic model_bit(input logic [W-1:0] op, input logic e, input int md);
    logic [7:0] v;
    v = model_vec(op);
    return e ? v[md] : 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press_mode();
    mode_step = 1'b1;
    tick(10);
    mode_step = 1'b0;
    tick(10);
    model_mode = (model_mode + 1) % 8;
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] op, input logic e);
    check({tag, "_vec"},  32'(out_vec),    e ? 32'(model_vec(op)) : 32'd0);
    check({tag, "_bit"},  32'(out_bit),    32'(model_bit(op, e, model_mode)));
    check({tag, "_ones"}, 32'(ones_count), 32'($countones(op)));
  endtask

  // Press sweep_start, optionally poke mode_step mid-sweep, and measure busy length.
  task automatic run_sweep(input logic inv, input logic poke_mode, output int busy_cycles);
    int waited;
    check_invert = inv;
    tick(3);
    sweep_start = 1'b1;
    waited = 0;
    while (!sweep_busy && waited < 40) begin
      tick(1);
      waited++;
    end
    check("sweep_busy_rise", 32'(sweep_busy), 32'd1);
    check("sweep_fail_clear_at_start", 32'(sweep_fail), 32'd0);
    sweep_start = 1'b0;
    if (poke_mode) mode_step = 1'b1;
    busy_cycles = 0;
    while (sweep_busy && busy_cycles < 40) begin
      busy_cycles++;
      tick(1);
    end
    check("sweep_done_after", 32'(sweep_done), 32'd1);
    check("sweep_busy_after", 32'(sweep_busy), 32'd0);
    mode_step = 1'b0;
    tick(12);
  endtask

  initial begin
    int busy_n;
    logic [W-1:0] op;
    logic e;

    // Reset state
    reset = 1'b0;
    tick(3);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    check("rst_out_bit", 32'(out_bit), 32'd0);
    check("rst_mode",    32'(mode),    32'd0);
    check("rst_ones",    32'(ones_count), 32'd0);
    check("rst_busy",    32'(sweep_busy), 32'd0);
    check("rst_done",    32'(sweep_done), 32'd0);
    check("rst_fail",    32'(sweep_fail), 32'd0);
    reset = 1'b1;
    tick(2);

    // Operand 110 with output enabled: nothing after 2 cycles, result on the 3rd
    en = 1'b1;
    in_bits = 3'b110;
    tick(2);
    check("lat2_vec", 32'(out_vec), 32'd0);
    tick(1);
    check_outputs("op110", 3'b110, 1'b1);

    // Operand 001 gated off, then enabled
    in_bits = 3'b001;
    en = 1'b0;
    tick(3);
    check_outputs("op001_off", 3'b001, 1'b0);
    en = 1'b1;
    tick(3);
    check_outputs("op001_on", 3'b001, 1'b1);

    // Random operands, enables and occasional mode steps
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(3) == 0) press_mode();
      op = W'($urandom);
      e  = ($urandom_range(4) != 0);
      in_bits = op;
      en = e;
      tick(3);
      check_outputs("rand", op, e);
      check("rand_mode", 32'(mode), 32'(model_mode));
    end

    // Debounce: 3-cycle glitch ignored, exactly DB cycles accepted
    mode_step = 1'b1;
    tick(3);
    mode_step = 1'b0;
    tick(10);
    check("glitch3_mode", 32'(mode), 32'(model_mode));
    mode_step = 1'b1;
    tick(4);
    mode_step = 1'b0;
    tick(10);
    model_mode = (model_mode + 1) % 8;
    check("press4_mode", 32'(mode), 32'(model_mode));
    mode_step = 1'b1;
    tick(20);
    mode_step = 1'b0;
    tick(10);
    model_mode = (model_mode + 1) % 8;
    check("hold20_mode", 32'(mode), 32'(model_mode));

    // Eight presses return the mode to where it started
    for (int k = 0; k < 8; k++) press_mode();
    check("eight_press_mode", 32'(mode), 32'(model_mode));

    // Clean sweep with a mode press landing inside it
    run_sweep(1'b0, 1'b1, busy_n);
    check("sweep_len", 32'(busy_n), 32'(1 << W));
    check("sweep_fail_clean", 32'(sweep_fail), 32'd0);
    check("sweep_mode_locked", 32'(mode), 32'(model_mode));

    // Inverted reference must fail; a following clean sweep clears it
    run_sweep(1'b1, 1'b0, busy_n);
    check("inv_sweep_len", 32'(busy_n), 32'(1 << W));
    check("inv_sweep_fail", 32'(sweep_fail), 32'd1);
    run_sweep(1'b0, 1'b0, busy_n);
    check("resweep_fail", 32'(sweep_fail), 32'd0);
    check("resweep_done", 32'(sweep_done), 32'd1);

    // Reset asserted mid-sweep
    press_mode();
    check("pre_abort_mode", 32'(mode), 32'(model_mode));
    sweep_start = 1'b1;
    busy_n = 0;
    while (!sweep_busy && busy_n < 40) begin
      tick(1);
      busy_n++;
    end
    check("abort_busy_rise", 32'(sweep_busy), 32'd1);
    sweep_start = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    model_mode = 0;
    check("abort_busy",    32'(sweep_busy), 32'd0);
    check("abort_done",    32'(sweep_done), 32'd0);
    check("abort_mode",    32'(mode),       32'd0);
    check("abort_out_vec", 32'(out_vec),    32'd0);
    check("abort_out_bit", 32'(out_bit),    32'd0);
    check("abort_ones",    32'(ones_count), 32'd0);
    check("abort_fail",    32'(sweep_fail), 32'd0);
    tick(2);
    reset = 1'b1;

    // Normal operation resumes after reset
    op = W'($urandom);
    in_bits = op;
    en = 1'b1;
    tick(4);
    check_outputs("post_reset", op, 1'b1);
    check("post_reset_idle", 32'(sweep_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
